// File: rtl/lux_sample_averager.sv
// Fetches 2**LOG2_N sensor readings on each request edge and returns their rounded mean.
// Latency: 1 + N*(D+1) + (N-1)*GAP_CYCLES cycles from start edge to avg_ready (D = sensor delay).
// Backpressure: sens_valid is held until sens_ready; a request edge while busy is dropped, not queued.
module lux_sample_averager #(
   parameter int LOG2_N         = 2,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int GAP_CYCLES     = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       avg_ready,
   output logic [7:0] avg_data,
   output logic       avg_err,
   output logic       busy,
   output logic       sens_valid,
   input  logic       sens_ready,
   input  logic [7:0] sens_data
);

   // Accumulator holds 255 * 2**LOG2_N plus the rounding bias without overflow.
   localparam int AW = 8 + LOG2_N;
   localparam int CW = LOG2_N + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   localparam logic [CW-1:0] N_SAMPLES  = CW'(2 ** LOG2_N);
   // Half an LSB of the final shift; zero in single-reading passthrough.
   localparam logic [AW-1:0] ROUND_BIAS = AW'((2 ** LOG2_N) / 2);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_GAP,
      ST_DONE,
      ST_ERR
   } state_t;

   state_t        state_q, state_d;
   logic          req_q, req_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          avg_ready_q, avg_ready_d;
   logic [7:0]    avg_data_q, avg_data_d;
   logic          avg_err_q, avg_err_d;

   logic          start;
   logic [CW-1:0] cnt_inc;
   logic [AW-1:0] rounded_sum;
   logic [7:0]    mean;

   // Next-state and datapath: edge detect, accumulate, timeout, and result capture.
   always_comb begin
      state_d     = state_q;
      req_d       = req_valid;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      timer_d     = timer_q;
      gap_d       = gap_q;
      avg_ready_d = 1'b0;
      avg_data_d  = avg_data_q;
      avg_err_d   = avg_err_q;

      start       = req_valid & ~req_q;
      cnt_inc     = cnt_q + 1'b1;
      rounded_sum = acc_q + ROUND_BIAS;
      mean        = 8'(rounded_sum >> LOG2_N);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               acc_d   = '0;
               cnt_d   = '0;
               timer_d = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A reading on the last allowed cycle still wins over the timeout.
            if (sens_ready) begin
               acc_d   = acc_q + AW'(sens_data);
               cnt_d   = cnt_inc;
               timer_d = '0;
               gap_d   = '0;
               state_d = (cnt_inc == N_SAMPLES) ? ST_DONE : ST_GAP;
            end else if (timer_q == TIMER_LAST) begin
               state_d = ST_ERR;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_GAP: begin
            // sens_valid is low here; any stray sens_ready is ignored.
            if (gap_q == GAP_LAST) begin
               state_d = ST_WAIT;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         ST_DONE: begin
            avg_ready_d = 1'b1;
            avg_err_d   = 1'b0;
            avg_data_d  = mean;
            state_d     = ST_IDLE;
         end
         ST_ERR: begin
            avg_ready_d = 1'b1;
            avg_err_d   = 1'b1;
            avg_data_d  = 8'h00;
            state_d     = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transaction without a result pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         req_q       <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         timer_q     <= '0;
         gap_q       <= '0;
         avg_ready_q <= 1'b0;
         avg_data_q  <= 8'h00;
         avg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         timer_q     <= timer_d;
         gap_q       <= gap_d;
         avg_ready_q <= avg_ready_d;
         avg_data_q  <= avg_data_d;
         avg_err_q   <= avg_err_d;
      end
   end

   assign avg_ready  = avg_ready_q;
   assign avg_data   = avg_data_q;
   assign avg_err    = avg_err_q;
   assign busy       = (state_q != ST_IDLE);
   assign sens_valid = (state_q == ST_WAIT);

endmodule

// File: tb/tb_lux_sample_averager.sv
// Directed bench for lux_sample_averager: a 4-sample instance and a passthrough instance.
// Latency is counted in clock edges from the request edge to the avg_ready pulse.
// The bench plays the sensor, answering sens_valid after a chosen delay.
module tb_lux_sample_averager;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rst;
   logic       req0, req1;
   logic       ar0, ar1, err0, err1, busy0, busy1, sv0, sv1;
   logic [7:0] ad0, ad1;
   logic       sr0, sr1;
   logic [7:0] sd0, sd1;

   lux_sample_averager #(.LOG2_N(2), .TIMEOUT_CYCLES(16), .GAP_CYCLES(1)) u0 (
      .clk(clk), .rst(rst), .req_valid(req0),
      .avg_ready(ar0), .avg_data(ad0), .avg_err(err0), .busy(busy0),
      .sens_valid(sv0), .sens_ready(sr0), .sens_data(sd0)
   );

   lux_sample_averager #(.LOG2_N(0), .TIMEOUT_CYCLES(16), .GAP_CYCLES(1)) u1 (
      .clk(clk), .rst(rst), .req_valid(req1),
      .avg_ready(ar1), .avg_data(ad1), .avg_err(err1), .busy(busy1),
      .sens_valid(sv1), .sens_ready(sr1), .sens_data(sd1)
   );

   int checks = 0;
   int errors = 0;
   int start_cyc = 0;
   int lat;
   int pulses;
   logic [7:0] seen_data;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Raise req on the selected instance; the following edge is the start edge.
   task automatic start_req(input bit sel, input bit hold);
      if (sel) req1 = 1'b1; else req0 = 1'b1;
      tick();
      start_cyc = cyc;
      if (!hold) begin
         if (sel) req1 = 1'b0; else req0 = 1'b0;
      end
   endtask

   // Sensor: wait for sens_valid, delay dly cycles, then pulse sens_ready with d.
   task automatic give(input bit sel, input logic [7:0] d, input int dly);
      int n;
      n = 0;
      while (((sel ? sv1 : sv0) !== 1'b1) && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) check("sens_valid_wait", 32'(sel ? sv1 : sv0), 32'd1);
      repeat (dly) tick();
      if (sel) begin sr1 = 1'b1; sd1 = d; end
      else     begin sr0 = 1'b1; sd0 = d; end
      tick();
      if (sel) begin sr1 = 1'b0; sd1 = 8'h00; end
      else     begin sr0 = 1'b0; sd0 = 8'h00; end
   endtask

   // Wait for avg_ready and return edges elapsed since the start edge.
   task automatic wait_avg(input bit sel, output int latency);
      int n;
      n = 0;
      while (((sel ? ar1 : ar0) !== 1'b1) && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) check("avg_ready_wait", 32'(sel ? ar1 : ar0), 32'd1);
      latency = cyc - start_cyc;
   endtask

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      sr0 = 1'b0; sr1 = 1'b0; sd0 = 8'h00; sd1 = 8'h00;
      tick();
      tick();
      rst = 1'b0;
      check("rst_avg_ready", 32'(ar0), 32'd0);
      check("rst_avg_data", 32'(ad0), 32'd0);
      check("rst_avg_err", 32'(err0), 32'd0);
      check("rst_busy", 32'(busy0), 32'd0);
      check("rst_sens_valid", 32'(sv0), 32'd0);
      tick();

      // 1: readings 10..13 with D=3 -> 12, 20 edges after start.
      start_req(1'b0, 1'b0);
      check("t1_busy", 32'(busy0), 32'd1);
      check("t1_sens_valid", 32'(sv0), 32'd1);
      give(1'b0, 8'd10, 3);
      give(1'b0, 8'd11, 3);
      give(1'b0, 8'd12, 3);
      give(1'b0, 8'd13, 3);
      wait_avg(1'b0, lat);
      check("t1_latency", 32'(lat), 32'd20);
      check("t1_data", 32'(ad0), 32'd12);
      check("t1_err", 32'(err0), 32'd0);
      check("t1_busy_done", 32'(busy0), 32'd0);
      tick();
      check("t1_pulse_width", 32'(ar0), 32'd0);
      check("t1_data_held", 32'(ad0), 32'd12);

      // 2: full-scale and rounding cases.
      start_req(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) give(1'b0, 8'd255, 1);
      wait_avg(1'b0, lat);
      check("t2_max_data", 32'(ad0), 32'd255);
      check("t2_max_latency", 32'(lat), 32'd12);
      tick();
      start_req(1'b0, 1'b0);
      give(1'b0, 8'd1, 0);
      give(1'b0, 8'd2, 0);
      give(1'b0, 8'd2, 0);
      give(1'b0, 8'd2, 0);
      wait_avg(1'b0, lat);
      check("t2_round_data", 32'(ad0), 32'd2);
      check("t2_round_latency", 32'(lat), 32'd8);
      tick();
      start_req(1'b1, 1'b0);
      give(1'b1, 8'd77, 2);
      wait_avg(1'b1, lat);
      check("t2_pass_data", 32'(ad1), 32'd77);
      check("t2_pass_err", 32'(err1), 32'd0);
      check("t2_pass_latency", 32'(lat), 32'd4);
      tick();
      check("t2_pass_busy", 32'(busy1), 32'd0);

      // 3: dead sensor -> ERR after 16 WAIT cycles.
      start_req(1'b0, 1'b0);
      wait_avg(1'b0, lat);
      check("t3_latency", 32'(lat), 32'd17);
      check("t3_err", 32'(err0), 32'd1);
      check("t3_data", 32'(ad0), 32'd0);
      check("t3_sens_valid", 32'(sv0), 32'd0);
      tick();
      check("t3_err_held", 32'(err0), 32'd1);

      // 4: reading on the final timeout cycle, stray sens_ready in GAP.
      start_req(1'b0, 1'b0);
      give(1'b0, 8'd20, 15);
      sr0 = 1'b1; sd0 = 8'd200;
      tick();
      sr0 = 1'b0; sd0 = 8'h00;
      give(1'b0, 8'd30, 0);
      give(1'b0, 8'd40, 0);
      give(1'b0, 8'd50, 0);
      wait_avg(1'b0, lat);
      check("t4_err", 32'(err0), 32'd0);
      check("t4_data", 32'(ad0), 32'd35);
      check("t4_latency", 32'(lat), 32'd23);
      tick();

      // 5: reset mid-transaction, then a clean transaction.
      start_req(1'b0, 1'b0);
      give(1'b0, 8'd90, 1);
      give(1'b0, 8'd91, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_busy", 32'(busy0), 32'd0);
      check("t5_sens_valid", 32'(sv0), 32'd0);
      check("t5_avg_ready", 32'(ar0), 32'd0);
      check("t5_avg_data", 32'(ad0), 32'd0);
      check("t5_avg_err", 32'(err0), 32'd0);
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (ar0 === 1'b1) pulses++;
      end
      check("t5_no_pulse", 32'(pulses), 32'd0);
      start_req(1'b0, 1'b0);
      give(1'b0, 8'd100, 0);
      give(1'b0, 8'd101, 0);
      give(1'b0, 8'd102, 0);
      give(1'b0, 8'd104, 0);
      wait_avg(1'b0, lat);
      check("t5_data", 32'(ad0), 32'd102);
      check("t5_latency", 32'(lat), 32'd8);
      tick();

      // 6: req held high, plus an edge while busy -> exactly one result.
      pulses = 0;
      seen_data = 8'h00;
      start_req(1'b0, 1'b1);
      give(1'b0, 8'd8, 1);
      req0 = 1'b0;
      tick();
      req0 = 1'b1;
      give(1'b0, 8'd8, 1);
      give(1'b0, 8'd8, 1);
      give(1'b0, 8'd8, 1);
      for (int i = 0; i < 180; i++) begin
         if (ar0 === 1'b1) begin
            pulses++;
            seen_data = ad0;
         end
         tick();
      end
      check("t6_pulses", 32'(pulses), 32'd1);
      check("t6_data", 32'(seen_data), 32'd8);
      check("t6_idle", 32'(busy0), 32'd0);
      req0 = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
